// File: rtl/done_dispatch.sv
// done_dispatch: issue-side dispatcher for the execution stage.
// Accepts one instruction at a time, pulses the start line of every
// participating unit, tracks their done handshakes and reports either a
// single stageDone pulse or a timeout when some unit never answers.
// Unit bit order everywhere: [0] branch, [1] jump, [2] memWrite1, [3] memWrite2.
// TIMEOUT_CYCLES must lie in 1..255 and 2**CNT_W must exceed it.

module done_dispatch #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       issueValid,
   input  logic [3:0] needMask,
   input  logic       branchDone,
   input  logic       jumpDone,
   input  logic       memWriteDone1,
   input  logic       memWriteDone2,
   input  logic       clearErr,
   output logic       issueReady,
   output logic       branchStart,
   output logic       jumpStart,
   output logic       memWriteStart1,
   output logic       memWriteStart2,
   output logic       stageDone,
   output logic       timeoutErr,
   output logic [3:0] pendingMask
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } stateType;

   // waitCnt holds (WAIT cycle number - 1) during WAIT, so the last allowed
   // WAIT cycle is the one where the count equals TIMEOUT_CYCLES-1.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   stateType         state;
   stateType         stateNext;
   logic [3:0]       needReg;
   logic [CNT_W-1:0] waitCnt;
   logic [3:0]       doneVec;
   logic [3:0]       maskAfter;
   logic             waitExpired;
   logic [3:0]       startVec;

   // Done inputs gathered in unit bit order; only pending units can be cleared,
   // so a held level or a repeated pulse from a finished unit has no effect.
   assign doneVec     = {memWriteDone2, memWriteDone1, jumpDone, branchDone};
   assign maskAfter   = pendingMask & ~doneVec;
   assign waitExpired = (waitCnt >= WAIT_LAST);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of block ordering.
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state decision; completion is judged on the post-update mask so a
   // done arriving on the last allowed WAIT cycle beats the timeout.
   always_comb begin
      // NOTE: default first, so no path through the case leaves stateNext
      // unassigned and infers a latch.
      stateNext = state;
      case (state)
         S_IDLE: begin
            if (issueValid) begin
               stateNext = (needMask == 4'b0000) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            stateNext = S_WAIT;
         end
         S_WAIT: begin
            if (maskAfter == 4'b0000) begin
               stateNext = S_DONE;
            end else if (waitExpired) begin
               stateNext = S_ERROR;
            end
         end
         S_DONE: begin
            stateNext = S_IDLE;
         end
         S_ERROR: begin
            if (clearErr) begin
               stateNext = S_IDLE;
            end
         end
         default: begin
            stateNext = S_IDLE;
         end
      endcase
   end

   // Latch the participating-unit mask when an instruction is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         needReg <= 4'b0000;
      end else if (state == S_IDLE && issueValid) begin
         needReg <= needMask;
      end
   end

   // Pending-unit tracking: loaded as the starts go out, whittled down by
   // dones while waiting, frozen in ERROR so the stuck units stay visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pendingMask <= 4'b0000;
      end else begin
         case (state)
            S_ISSUE: pendingMask <= needReg;
            S_WAIT:  pendingMask <= maskAfter;
            S_DONE:  pendingMask <= 4'b0000;
            S_ERROR: begin
               if (clearErr) begin
                  pendingMask <= 4'b0000;
               end
            end
            default: pendingMask <= pendingMask;
         endcase
      end
   end

   // Watchdog: cleared on issue, counts WAIT cycles and saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         waitCnt <= '0;
      end else if (state == S_ISSUE) begin
         waitCnt <= '0;
      end else if (state == S_WAIT && waitCnt != CNT_MAX) begin
         waitCnt <= waitCnt + 1'b1;
      end
   end

   // Outputs decoded purely from registered state; no input reaches an output.
   always_comb begin
      issueReady = 1'b0;
      stageDone  = 1'b0;
      timeoutErr = 1'b0;
      startVec   = 4'b0000;
      case (state)
         S_IDLE:  issueReady = 1'b1;
         S_ISSUE: startVec   = needReg;
         S_DONE:  stageDone  = 1'b1;
         S_ERROR: timeoutErr = 1'b1;
         default: begin
            issueReady = 1'b0;
         end
      endcase
   end

   assign branchStart    = startVec[0];
   assign jumpStart      = startVec[1];
   assign memWriteStart1 = startVec[2];
   assign memWriteStart2 = startVec[3];

endmodule

// File: doc/done_dispatch.md
Name: done_dispatch

Overview:
- Issue-side counterpart of the execution-stage completion logic.
- Accepts one instruction at a time and fires one-cycle start pulses to the participating units: branch, jump, memory-write port 1, memory-write port 2.
- Tracks each unit's done handshake and emits a single stageDone pulse once every started unit has reported.
- A watchdog counter flags any unit that never reports.

Parameters:
- TIMEOUT_CYCLES, 64, number of WAIT cycles allowed before declaring a timeout (legal range 1..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- issueValid  input  1  request to execute one instruction; sampled only while issueReady=1.
- needMask  input  4  participating units, sampled with issueValid. Bit order: [0] branch, [1] jump, [2] memWrite1, [3] memWrite2.
- branchDone  input  1  completion pulse/level from the branch unit.
- jumpDone  input  1  completion from the jump unit.
- memWriteDone1  input  1  completion from memory-write port 1.
- memWriteDone2  input  1  completion from memory-write port 2.
- clearErr  input  1  acknowledges a timeout; honoured only in ERROR.
- issueReady  output  1  high in IDLE only.
- branchStart  output  1  one-cycle start pulse to the branch unit.
- jumpStart  output  1  one-cycle start pulse to the jump unit.
- memWriteStart1  output  1  one-cycle start pulse to memory-write port 1.
- memWriteStart2  output  1  one-cycle start pulse to memory-write port 2.
- stageDone  output  1  one-cycle pulse: all needed units completed.
- timeoutErr  output  1  high throughout ERROR.
- pendingMask  output  4  units started but not yet done; same bit order as needMask.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, ERROR. All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Reset (reset=0, asynchronous; any state, including mid-operation):
  - state goes to IDLE; pendingMask=0, waitCnt=0.
  - all start outputs 0, stageDone=0, timeoutErr=0, issueReady=1.
  - Units already started are not tracked after reset.
- IDLE:
  - issueReady=1.
  - On issueValid=1, latch needMask.
  - needMask=0: go directly to DONE.
  - needMask≠0: go to ISSUE.
- ISSUE (exactly one cycle):
  - Each start output = its latched needMask bit.
  - pendingMask loaded with needMask; waitCnt cleared.
  - Done inputs ignored this cycle.
  - Next state WAIT.
- WAIT:
  - Each cycle, pendingMask &= ~{memWriteDone2, memWriteDone1, jumpDone, branchDone}.
  - Done from a unit not pending is ignored, so a level held high or a repeated pulse is harmless.
  - waitCnt increments by 1 per WAIT cycle and saturates.
  - Next state is decided on the post-update mask:
    - Mask reaches 0 on any cycle → DONE.
    - Otherwise, on WAIT cycle number TIMEOUT_CYCLES → ERROR.
  - Done arriving on the final allowed cycle wins over timeout.
- DONE:
  - stageDone=1 for exactly one cycle; pendingMask=0.
  - Next state IDLE; issueReady returns the following cycle.
- ERROR:
  - timeoutErr=1; pendingMask frozen, showing the stuck units; late done inputs ignored.
  - clearErr=1 → IDLE with pendingMask cleared. No stageDone is issued for the aborted instruction.
- issueValid outside IDLE: ignored, not queued.
- clearErr outside ERROR: ignored.
- Latency (issueValid accepted at edge 0):
  - Start pulses during cycle 1.
  - Earliest stageDone during cycle 3, when all dones arrive in the first WAIT cycle.
  - Empty mask: stageDone during cycle 1.
- Throughput: back-to-back issueValid gives at most one instruction per 4 cycles.

Test Plan:
- Reset release, then issueValid with needMask=4'b0011 → branchStart and jumpStart high for exactly one cycle. Drive branchDone in WAIT cycle 1 and jumpDone in WAIT cycle 3 → pendingMask 0011→0010→0000, stageDone one cycle after the jumpDone cycle, issueReady high next.
- needMask=4'b0000 → no start pulses, stageDone exactly one cycle after acceptance.
- needMask=4'b1111 with all four dones high in the same first WAIT cycle → stageDone in the following cycle. Spurious jumpDone during ISSUE is ignored; pendingMask stays 1111 until the WAIT sample.
- TIMEOUT_CYCLES=4, needMask=4'b0100, memWriteDone1 never asserted → timeoutErr after WAIT cycle 4, pendingMask=0100, no stageDone. clearErr → issueReady=1 next cycle.
- TIMEOUT_CYCLES=4, memWriteDone1 asserted on WAIT cycle 4 exactly → DONE and stageDone, no timeoutErr.
- reset driven low mid-WAIT, asynchronously between edges → outputs immediately at reset values; a subsequent issue behaves normally.
